uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receive stage; consumes the tx_out line of the transmit stage.
//  Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); line idles high.
//  Oversamples rx_in at OVS x bit rate and mid-bit samples each bit.
//  Assembles the byte in a shift register (RSR), then transfers it to a hold register (RHR).
//  Presents RHR with a ready flag and sticky error flags to the host.
// PARAMETERS
//  OVS        16   bclk cycles per bit period; even, >= 4.
//  SYNC_STAGES 2   metastability flops on rx_in; >= 2.
// PORTS
//  bclk         in   1  receive clock, OVS x bit rate; all state on posedge.
//  reset        in   1  asynchronous, active-high reset.
//  rx_in        in   1  serial line, asynchronous to bclk.
//  rd           in   1  single-cycle read strobe; clears rx_ready and both error flags.
//  d_out        out  8  RHR contents; stable while rx_ready=1.
//  rx_ready     out  1  1 = unread byte in RHR.
//  framing_err  out  1  sticky; stop bit sampled 0.
//  overrun_err  out  1  sticky; new byte completed while rx_ready=1.
//  rx_busy      out  1  1 = FSM not in IDLE.
// BEHAVIOUR
//  Reset, asynchronous, active-high; applies immediately, also mid-frame:
//   - outputs: d_out=0, rx_ready=0, framing_err=0, overrun_err=0, rx_busy=0.
//   - internal: FSM=IDLE, synchroniser flops=1, counters=0.
//  Synchroniser:
//   - rx_s is rx_in delayed by SYNC_STAGES flops.
//   - t0 = the first cycle in IDLE where rx_s=0 and the previous rx_s=1.
//  FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
//  Tick counter tc (clog2(OVS) bits) and bit counter bc (3 bits).
//  IDLE -> START at t0; tc cleared.
//  START: at t0+OVS/2-1, sample rx_s.
//   - rx_s=1: false start, return to IDLE; no flags change.
//   - rx_s=0: go to DATA; tc=0, bc=0.
//  DATA: sample bit i at t0+OVS/2-1+OVS*(i+1); shift right into RSR[7], so LSB is first in.
//   - after bc=7 is sampled, go to STOP.
//  STOP: sample at t0+OVS/2-1+9*OVS.
//   - rx_s=1: transfer RSR->RHR on the next edge; rx_ready=1; go to IDLE.
//   - rx_s=0: RSR is discarded, RHR unchanged; framing_err=1; go to WAIT_IDLE.
//  WAIT_IDLE: stay until rx_s=1, then IDLE. A held-low break yields exactly one framing_err.
//  Latency: rx_ready rises at t0+OVS/2+9*OVS, i.e. t0+152 for OVS=16.
//  Overrun: a transfer attempted while rx_ready=1 and rd=0 sets overrun_err.
//   - RHR keeps the older byte; the new byte is dropped.
//  rd coinciding with a transfer: new byte loads, rx_ready stays 1, no overrun.
//  rd with rx_ready=0: clears only the error flags; otherwise a no-op.
//  rd same cycle as a framing-error sample: the error is set, and the set wins over the clear.
//  Back-to-back frames: a new start edge is accepted the cycle after returning to IDLE.
//   - Minimum gap between frames = 0 extra idle bits.
//  rx_busy = (state != IDLE).
//  Arithmetic: tc wraps modulo OVS; bc saturates; no other arithmetic.
// STRUCTURE
//  Package uart_pkg: shared with the transmitter.
//   - state localparams RX_IDLE..RX_WAIT_IDLE.
//   - UART_DATA_BITS=8, UART_IDLE_LVL=1'b1, UART_START_LVL=1'b0.
//  Sub-module uart_rx_sync: SYNC_STAGES-deep synchroniser, reset-to-1, output rx_s.
//  Top level holds the FSM, counters, RSR, RHR and flags in one registered always block.
//  Next-state logic is combinational with a default assignment, so no latches.
// TESTING
//  All cases use OVS=16, with rx_in driven by a bench model at 16 bclk/bit.
//  1. Frame 0xA5, clean line -> rx_ready at t0+152, d_out=8'hA5, both errors 0; rd -> rx_ready=0.
//  2. 0x3C then 0xC3 back-to-back, rd after each -> d_out 3C then C3, no errors.
//  3. 0x11 unread, then 0x22 arrives -> overrun_err=1, d_out stays 11; rd clears all.
//  4. Frame 0x55 with stop bit forced 0 -> framing_err=1, rx_ready=0.
//     Line then held low 40 bits -> no further events; after release the next 0x0F is received.
//  5. Glitch: rx_in low 4 bclk then high -> false start; FSM back to IDLE, no flags, rx_ready=0.
//  6. reset asserted mid-DATA (bit 4 of 0xFF) -> all outputs 0 at once.
//     After release, a fresh frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit and receive stages: frame geometry,
//   line levels and the receive FSM state encoding.
//   No ports (package).
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
//   Metastability synchroniser for the asynchronous serial line. The chain
//   resets to the idle level so that releasing reset never looks like a start
//   edge.
// Ports
//   bclk   in   receive clock
//   reset  in   asynchronous, active-high reset
//   rx_in  in   raw serial line
//   rx_s   out  rx_in delayed by SYNC_STAGES flops
// ----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic bclk,
    input  logic reset,
    input  logic rx_in,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            sync_ff <= {SYNC_STAGES{UART_IDLE_LVL}};
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rx_s = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
//   Serial-to-parallel UART receive stage. Frame: start(0), 8 data bits LSB
//   first, stop(1); line idles high. rx_in is oversampled at OVS x bit rate and
//   each bit is sampled once near its middle. The byte is assembled in RSR and
//   transferred to RHR, which is presented with a ready flag and sticky errors.
// Ports
//   bclk         in   receive clock, OVS x bit rate
//   reset        in   asynchronous, active-high reset
//   rx_in        in   serial line, asynchronous to bclk
//   rd           in   single-cycle read strobe; clears rx_ready and errors
//   d_out        out  RHR contents
//   rx_ready     out  unread byte in RHR
//   framing_err  out  sticky: stop bit sampled low
//   overrun_err  out  sticky: byte completed while rx_ready was set
//   rx_busy      out  FSM not idle
// ----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      bclk,
    input  logic                      reset,
    input  logic                      rx_in,
    input  logic                      rd,
    output logic [UART_DATA_BITS-1:0] d_out,
    output logic                      rx_ready,
    output logic                      framing_err,
    output logic                      overrun_err,
    output logic                      rx_busy
);

    localparam int              TC_W    = $clog2(OVS);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVS - 1);
    localparam logic [TC_W-1:0] TC_ONE  = TC_W'(1);
    // START is entered one cycle after the detected edge, so the mid-point of
    // the start bit is reached when tc reads OVS/2-2.
    localparam logic [TC_W-1:0] TC_MID  = TC_W'(OVS / 2 - 2);

    function automatic logic [TC_W-1:0] tc_inc(input logic [TC_W-1:0] v);
        return (v == TC_LAST) ? '0 : v + TC_ONE;
    endfunction

    function automatic logic [2:0] bc_sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    logic                      rx_s;
    logic                      rx_s_prev;
    logic                      start_edge;
    rx_state_t                 state, state_nxt;
    logic [TC_W-1:0]           tc, tc_nxt;
    logic [2:0]                bc, bc_nxt;
    logic [UART_DATA_BITS-1:0] rsr, rsr_nxt;
    logic [UART_DATA_BITS-1:0] rhr_nxt;
    logic                      ready_nxt, ferr_nxt, oerr_nxt;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .bclk  (bclk),
        .reset (reset),
        .rx_in (rx_in),
        .rx_s  (rx_s)
    );

    assign start_edge = (rx_s == UART_START_LVL) && (rx_s_prev == UART_IDLE_LVL);

    always_comb begin
        state_nxt = state;
        tc_nxt    = tc;
        bc_nxt    = bc;
        rsr_nxt   = rsr;
        rhr_nxt   = d_out;
        ready_nxt = rx_ready;
        ferr_nxt  = framing_err;
        oerr_nxt  = overrun_err;

        // The read clear is applied first so that any flag set below wins.
        if (rd) begin
            ready_nxt = 1'b0;
            ferr_nxt  = 1'b0;
            oerr_nxt  = 1'b0;
        end

        case (state)
            RX_IDLE: begin
                if (start_edge) begin
                    state_nxt = RX_START;
                    tc_nxt    = '0;
                end
            end
            RX_START: begin
                if (tc == TC_MID) begin
                    if (rx_s == UART_IDLE_LVL) begin
                        state_nxt = RX_IDLE;
                    end else begin
                        state_nxt = RX_DATA;
                        tc_nxt    = '0;
                        bc_nxt    = '0;
                    end
                end else begin
                    tc_nxt = tc_inc(tc);
                end
            end
            RX_DATA: begin
                tc_nxt = tc_inc(tc);
                if (tc == TC_LAST) begin
                    rsr_nxt = {rx_s, rsr[UART_DATA_BITS-1:1]};
                    bc_nxt  = bc_sat_inc(bc);
                    if (bc == 3'd7) begin
                        state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                tc_nxt = tc_inc(tc);
                if (tc == TC_LAST) begin
                    if (rx_s == UART_IDLE_LVL) begin
                        state_nxt = RX_IDLE;
                        // A read in this same cycle frees RHR for the new byte.
                        if (rx_ready && !rd) begin
                            oerr_nxt = 1'b1;
                        end else begin
                            rhr_nxt   = rsr;
                            ready_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = RX_WAIT_IDLE;
                        ferr_nxt  = 1'b1;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s == UART_IDLE_LVL) begin
                    state_nxt = RX_IDLE;
                end
            end
            default: begin
                state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            state       <= RX_IDLE;
            rx_s_prev   <= UART_IDLE_LVL;
            tc          <= '0;
            bc          <= '0;
            rsr         <= '0;
            d_out       <= '0;
            rx_ready    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_s_prev   <= rx_s;
            tc          <= tc_nxt;
            bc          <= bc_nxt;
            rsr         <= rsr_nxt;
            d_out       <= rhr_nxt;
            rx_ready    <= ready_nxt;
            framing_err <= ferr_nxt;
            overrun_err <= oerr_nxt;
            rx_busy     <= (state_nxt != RX_IDLE);
        end
    end

endmodule
